// File: rtl/vram_controller.sv
`default_nettype none
// ============================================================================
// Module      : vram_controller
// Description : Single-frame RGB444 buffer fed by an 8-bit CMOS camera, with a
//               synchronous read port. Define VRAM_WR_FORWARD_EN for
//               write-first forwarding on same-address read/write.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_controller #(
    parameter int ADDR_WIDTH = $clog2(76800),
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 76800
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  href_cmos_i,
    input  logic [7:0]            pixel_data_cmos_i,
    input  logic [ADDR_WIDTH-1:0] pixel_read_address_i,
    output logic [DATA_WIDTH-1:0] pixel_data_o
);

    localparam logic [0:0] ST_FIRST  = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_WIDE = (ADDR_WIDTH + 1)'(DEPTH);

    logic [0:0]            state;
    logic [3:0]            red_hold;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  write_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  read_in_range;

    assign write_en      = href_cmos_i && (state == ST_SECOND);
    assign wr_data       = DATA_WIDTH'({red_hold, pixel_data_cmos_i});
    assign read_in_range = ({1'b0, pixel_read_address_i} < DEPTH_WIDE);

    // Any gap in href restarts pixel assembly, so a half pixel is dropped.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= ST_FIRST;
            red_hold <= 4'h0;
        end else if (!href_cmos_i) begin
            state    <= ST_FIRST;
        end else if (state == ST_FIRST) begin
            state    <= ST_SECOND;
            red_hold <= pixel_data_cmos_i[3:0];
        end else begin
            state    <= ST_FIRST;
        end
    end

    // No vsync: frame alignment relies on reset plus an exact pixel count.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_addr <= '0;
        end else if (write_en) begin
            if (wr_addr == LAST_ADDR) begin
                wr_addr <= '0;
            end else begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (write_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pixel_data_o <= '0;
        end else if (!read_in_range) begin
            pixel_data_o <= '0;
`ifdef VRAM_WR_FORWARD_EN
        end else if (write_en && (pixel_read_address_i == wr_addr)) begin
            pixel_data_o <= wr_data;
`endif
        end else begin
            pixel_data_o <= mem[pixel_read_address_i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_controller.sv
`default_nettype none
// Scoreboard bench for vram_controller: randomized and directed byte streams
// against a frame-buffer model kept as plain arrays.
module tb_vram_controller;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 4095;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    cam_byte = 8'h00;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata;

    vram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i                (clk),
        .reset_i              (reset_n),
        .href_cmos_i          (href),
        .pixel_data_cmos_i    (cam_byte),
        .pixel_read_address_i (raddr),
        .pixel_data_o         (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    check;
        logic [11:0] val;
        string   name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference frame buffer
    logic [11:0] model_mem [DEPTH];
    bit          known [DEPTH];
    int          wptr = 0;
    bit          have_red = 0;
    logic [3:0]  red = 4'h0;
`ifdef VRAM_WR_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.check) begin
                vectors++;
                if (rdata !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", e.name, rdata, e.val);
                end
            end
        end
    end

    task automatic direct_check(input string name, input logic [11:0] want);
        vectors++;
        if (rdata !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, rdata, want);
        end
    endtask

    // One clock of stimulus: expectation derived from the model, then model updated.
    task automatic cyc(input bit h, input logic [7:0] b, input int ra, input string name);
        exp_t e;
        bit   wr;
        logic [11:0] newpix;
        @(negedge clk);
        href     = h;
        cam_byte = b;
        raddr    = AW'(ra);
        wr       = h && have_red;
        newpix   = {red, b};
        e.name   = name;
        if (ra >= DEPTH) begin
            e.check = 1'b1;
            e.val   = 12'h000;
        end else if (FWD && wr && ra == wptr) begin
            e.check = 1'b1;
            e.val   = newpix;
        end else begin
            e.check = known[ra];
            e.val   = model_mem[ra];
        end
        exp_q.push_back(e);
        if (!h) begin
            have_red = 0;
        end else if (have_red) begin
            model_mem[wptr] = newpix;
            known[wptr]     = 1'b1;
            wptr            = (wptr + 1) % DEPTH;
            have_red        = 0;
        end else begin
            red      = b[3:0];
            have_red = 1;
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        direct_check(name, 12'h000);
        have_red = 0;
        wptr     = 0;
        href     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pix(input logic [11:0] p, input string name);
        cyc(1'b1, {4'h0, p[11:8]}, int'($urandom_range(0, DEPTH - 1)), name);
        cyc(1'b1, p[7:0], int'($urandom_range(0, DEPTH - 1)), name);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = 1'b0;
            model_mem[i] = 12'h000;
        end
        repeat (3) @(posedge clk);
        #1;
        direct_check("reset_hold", 12'h000);
        @(negedge clk);
        reset_n = 1'b1;

        // Pixel assembly
        cyc(1'b1, 8'hA5, 0, "asm_b0");
        cyc(1'b1, 8'h3C, 0, "asm_b1");
        cyc(1'b0, 8'h00, 0, "asm_read0");
        if (model_mem[0] !== 12'h53C || !known[0]) begin
            miscompares++;
            $display("FAIL asm_model: got %h expected %h", model_mem[0], 12'h53C);
        end

        // Sequential write, then half-pixel drop
        do_reset("reset_async1");
        begin
            logic [7:0] seq [8];
            seq = '{8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};
            for (int i = 0; i < 8; i++) cyc(1'b1, seq[i], DEPTH + i, "seq_oor");
        end
        cyc(1'b0, 8'h00, 5, "seq_gap");
        cyc(1'b1, 8'h0F, 6, "half_b0");
        cyc(1'b0, 8'h00, 7, "half_drop");
        cyc(1'b1, 8'h02, 0, "seq_read0");
        cyc(1'b1, 8'h34, 1, "seq_read1");
        for (int a = 2; a < 6; a++) cyc(1'b0, 8'h00, a, "seq_read");
        if (model_mem[4] !== 12'h234) begin
            miscompares++;
            $display("FAIL half_model: got %h expected %h", model_mem[4], 12'h234);
        end

        // Reset mid-pixel loses the latched byte; next write goes to address 0
        cyc(1'b1, 8'h0F, 0, "mid_b0");
        do_reset("reset_async2");
        cyc(1'b1, 8'h0A, 4, "mid_after0");
        cyc(1'b1, 8'hBC, 0, "mid_after1");
        cyc(1'b0, 8'h00, 0, "mid_read0");

        // Collision at address 0: 0x111 stored, then 0x777 written while reading
        do_reset("reset_async3");
        cyc(1'b1, 8'h01, 0, "col_pre0");
        cyc(1'b1, 8'h11, 0, "col_pre1");
        do_reset("reset_async4");
        cyc(1'b1, 8'h07, 0, "col_b0");
        cyc(1'b1, 8'h77, 0, "col_same");
        cyc(1'b0, 8'h00, 0, "col_next");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int ra;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ra = int'($urandom_range(DEPTH, (1 << AW) - 1));
            else if (sel < 4)  ra = wptr;
            else               ra = int'($urandom_range(0, DEPTH - 1));
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ra, "random");
        end

        // Frame wrap: DEPTH+1 pixels, pixel k = k[11:0]
        do_reset("reset_async5");
        for (int k = 0; k <= DEPTH; k++) pix(12'(k), "wrap_stream");
        cyc(1'b0, 8'h00, 0, "wrap_addr0");
        cyc(1'b0, 8'h00, 1, "wrap_addr1");
        cyc(1'b0, 8'h00, DEPTH - 1, "wrap_last");
        cyc(1'b0, 8'h00, DEPTH, "oor_depth");
        cyc(1'b0, 8'h00, 76800, "oor_76800");
        cyc(1'b0, 8'h00, 131071, "oor_max");
        if (model_mem[0] !== 12'hFFF || model_mem[1] !== 12'h001) begin
            miscompares++;
            $display("FAIL wrap_model: got %h/%h expected fff/001", model_mem[0], model_mem[1]);
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
